// File: rtl/otp_ctrl_buf_loader.sv
// OTP buffered partition loader.
// On request, reads Depth consecutive 64-bit words from OTP, starting at
// BaseAddr, and writes each one into the partition register file. Any OTP
// read error, a register-file ECC error or a protocol violation parks the
// FSM in a terminal ERROR state. Only a reset leaves ERROR.
module otp_ctrl_buf_loader #(
  parameter int          Depth    = 16,
  parameter logic [10:0] BaseAddr = 11'h000,
  localparam int         Aw       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          init_req_i,
  output logic          init_done_o,
  output logic          busy_o,
  output logic          otp_req_o,
  output logic [10:0]   otp_addr_o,
  input  logic          otp_gnt_i,
  input  logic          otp_rvalid_i,
  input  logic [63:0]   otp_rdata_i,
  input  logic          otp_err_i,
  output logic          reg_wren_o,
  output logic [Aw-1:0] reg_addr_o,
  output logic [63:0]   reg_wdata_o,
  input  logic          reg_ecc_err_i,
  output logic [1:0]    err_code_o
);

  // Sparse state codes: every pair of codes differs in at least 3 bits, so a
  // single or double bit flip never turns one valid state into another.
  localparam logic [5:0] StIdle  = 6'b000000;
  localparam logic [5:0] StReq   = 6'b000111;
  localparam logic [5:0] StWait  = 6'b011001;
  localparam logic [5:0] StWrite = 6'b101010;
  localparam logic [5:0] StDone  = 6'b110100;
  localparam logic [5:0] StError = 6'b111111;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrOtp   = 2'd1;
  localparam logic [1:0] ErrEcc   = 2'd2;
  localparam logic [1:0] ErrProto = 2'd3;

  localparam logic [Aw-1:0] LastCnt = Aw'(Depth - 1);

  logic [5:0]    state_q, state_d;
  logic [Aw-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic [1:0]    err_q, err_d;

  // Next-state logic: load sequencing plus error and protocol checking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (otp_rvalid_i) begin
          state_d = StError;
          err_d   = ErrProto;
        end else if (init_req_i) begin
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (otp_rvalid_i) begin
          state_d = StError;
          err_d   = ErrProto;
        end else if (otp_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (otp_rvalid_i) begin
          if (otp_err_i) begin
            state_d = StError;
            err_d   = ErrOtp;
          end else begin
            data_d  = otp_rdata_i;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (otp_rvalid_i) begin
          state_d = StError;
          err_d   = ErrProto;
        end else if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StReq;
        end
      end
      StDone: begin
        if (otp_rvalid_i) begin
          state_d = StError;
          err_d   = ErrProto;
        end else if (reg_ecc_err_i) begin
          state_d = StError;
          err_d   = ErrEcc;
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
        err_d   = ErrProto;
      end
    endcase
  end

  // State, word counter, captured data and error code registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= ErrNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset forces them all low at once. Write data comes only from data_q.
  assign otp_req_o   = (state_q == StReq);
  assign reg_wren_o  = (state_q == StWrite);
  assign busy_o      = otp_req_o || (state_q == StWait) || reg_wren_o;
  assign init_done_o = (state_q == StDone);
  assign otp_addr_o  = otp_req_o ? (BaseAddr + 11'({cnt_q, 3'b000})) : 11'h000;
  assign reg_addr_o  = reg_wren_o ? cnt_q : '0;
  assign reg_wdata_o = reg_wren_o ? data_q : 64'h0;
  assign err_code_o  = err_q;

endmodule
